vga_text_writer: RTL and testbench
==================================

# vga_text_writer

Text-mode console writer that fills the VRAM character plane scanned out by the VGA text-mode path. It accepts 8-bit character codes over a valid/ready stream (from the CPU I/O port), keeps a cursor, interprets control codes, and writes `{4'h0, ch}` words into VRAM at `row*COLS + col`, the same layout the text-mode scan-out reads (80×30 cells, 8×16 glyphs). Scrolling and clear-screen are performed by an internal copy/fill state machine using the VRAM read port.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 30, rows per screen
- `ADDR_W`, 19, VRAM address width
- `DATA_W`, 12, VRAM word width; char code in bits [7:0], upper bits written 0
- `clk  in  1  system clock (25 MHz pixel domain)`
- `rst  in  1  reset; asynchronous, active-low`
- `ch_valid  in  1  character available`
- `ch_data  in  8  character code`
- `ch_ready  out  1  writer can accept; transfer on ch_valid && ch_ready at rising edge`
- `vram_we  out  1  VRAM write strobe (registered)`
- `vram_waddr  out  ADDR_W  write address (registered)`
- `vram_wdata  out  DATA_W  write data (registered)`
- `vram_raddr  out  ADDR_W  read address (registered)`
- `vram_rdata  in  DATA_W  read data, valid one cycle after vram_raddr`
- `cursor_col  out  7  current column, 0..COLS-1`
- `cursor_row  out  5  current row, 0..ROWS-1`
- `busy  out  1  high in any state other than IDLE`

## Operation
- States: IDLE, COPY, CLR_ROW, CLR_ALL. `ch_ready = (state == IDLE)`; `busy = !ch_ready`.
- Accepted code in IDLE (cursor `c`,`r`):
  - 0x0A (LF): col←0, row←r+1.
  - 0x0D (CR): col←0.
  - 0x08 (BS): if c>0, col←c-1 and write 0x20 at `r*COLS+c-1`; if c==0, no-op.
  - 0x0C (FF): enter CLR_ALL; cursor←(0,0).
  - Any other: write ch at `r*COLS+c`; col←c+1; if c==COLS-1, col←0, row←r+1.
- Row advance past ROWS-1 (LF or wrap on last row): row stays ROWS-1, enter COPY.
- COPY: counter i = 0..(ROWS-1)*COLS-1; each cycle issue `vram_raddr = i+COLS`; next cycle write `vram_rdata` to address i. Lasts (ROWS-1)*COLS+1 cycles (last write trails last read), then CLR_ROW.
- CLR_ROW: write 0x20 to addresses (ROWS-1)*COLS .. ROWS*COLS-1, one per cycle (COLS cycles), then IDLE.
- CLR_ALL: write 0x20 to addresses 0 .. ROWS*COLS-1, one per cycle, then IDLE.
- Address arithmetic in ADDR_W bits; max address ROWS*COLS-1 = 2399 at defaults.

## Timing
- Reset (rst low, async): state IDLE, cursor (0,0), vram_we 0, vram_waddr 0, vram_wdata 0, vram_raddr 0, ch_ready 1, busy 0. VRAM contents untouched.
- Reset mid-COPY/CLR: aborts immediately; partial VRAM contents remain.
- Character accepted at edge E: its write (vram_we=1) appears in cycle E..E+1; cursor outputs update at E.
- Printable/CR/LF/BS without scroll: ch_ready stays high; sustained 1 char/cycle.
- Scroll-triggering char at E: char write in cycle after E (same cycle as first COPY read); ch_ready low for (ROWS-1)*COLS+1+COLS = 2401 cycles; high again in the cycle after the last CLR_ROW write.
- FF at E: first clear write in cycle after E; ch_ready low for ROWS*COLS = 2400 cycles.
- vram_we deasserts the cycle after the final write of any operation.

## Configuration
- `VGA_WRITER_SCROLL_EN` defined: scrolling as above.
- Not defined: COPY and CLR_ROW not built; row advance past ROWS-1 wraps row to 0 with no clearing; ch_ready deasserts only for FF.

## Test plan
- Reset, send 'A' (0x41) -> write addr 0 data 0x041 one cycle later; cursor (1,0); ch_ready stays 1.
- Send 80 × 'x' back-to-back -> writes addr 0..79 on consecutive cycles; cursor (0,1).
- Cursor (5,3), send 0x08 -> write 0x020 at 244; cursor (4,3); at col 0 BS -> no write, cursor unchanged.
- Preload VRAM row r with value r+1, cursor (0,29), send 0x0A -> ch_ready low exactly 2401 cycles; row 0..28 hold 2..30; row 29 all 0x020; cursor (0,29). Without macro: cursor (0,0), no ready drop.
- Send 0x0C -> 2400 writes of 0x020 to 0..2399 consecutively; cursor (0,0); assert rst at cycle 1000 -> outputs at reset values immediately, addr 1000.. unwritten.

Source files
------------

// File: rtl/vga_text_writer_if.sv
// Character stream, VRAM write/read ports and status for the text-mode console writer.
interface vga_text_writer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              ch_valid;
    logic [7:0]        ch_data;
    logic              ch_ready;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_waddr;
    logic [DATA_W-1:0] vram_wdata;
    logic [ADDR_W-1:0] vram_raddr;
    logic [DATA_W-1:0] vram_rdata;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic              busy;

    modport master (
        input  ch_valid, ch_data, vram_rdata,
        output ch_ready, vram_we, vram_waddr, vram_wdata, vram_raddr,
        output cursor_col, cursor_row, busy
    );

    modport slave (
        output ch_valid, ch_data, vram_rdata,
        input  ch_ready, vram_we, vram_waddr, vram_wdata, vram_raddr,
        input  cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/vga_text_writer.sv
// Console writer: cursor, control codes and clear/scroll engine for the VRAM text plane.
// Scrolling is built only when VGA_WRITER_SCROLL_EN is defined; otherwise the row wraps to 0.
//
// state     | meaning
// S_IDLE    | accepting characters, one per cycle
// S_COPY    | moving rows 1..ROWS-1 up by one row
// S_CLR_ROW | blanking the last row after a scroll
// S_CLR_ALL | blanking the whole screen (form feed)
module vga_text_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input logic               clk,
    input logic               rst_n,
    vga_text_writer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_COPY, S_CLR_ROW, S_CLR_ALL} state_t;

    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] A_COLS   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(ROWS * COLS - 1);
    localparam logic [DATA_W-1:0] SPACE    = DATA_W'(8'h20);
`ifdef VGA_WRITER_SCROLL_EN
    localparam logic [ADDR_W-1:0] A_NCOPY   = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] A_COLS_M1 = ADDR_W'(COLS - 1);
`endif

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
    logic [6:0]        r_col, w_col_nx;
    logic [4:0]        r_row, w_row_nx;
    logic              r_we, w_we_nx;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nx;
    logic [DATA_W-1:0] r_wdata, w_wdata_nx;
    logic [ADDR_W-1:0] r_raddr, w_raddr_nx;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_adv_row;

    assign w_cur_addr = ADDR_W'(r_row) * A_COLS + ADDR_W'(r_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
            r_we    <= w_we_nx;
            r_waddr <= w_waddr_nx;
            r_wdata <= w_wdata_nx;
            r_raddr <= w_raddr_nx;
        end
    end

    // Every cycle stages at most one VRAM write; it becomes visible on the next cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_col_nx   = r_col;
        w_row_nx   = r_row;
        w_we_nx    = 1'b0;
        w_waddr_nx = r_waddr;
        w_wdata_nx = r_wdata;
        w_raddr_nx = r_raddr;
        w_adv_row  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ch_valid) begin
                    case (bus.ch_data)
                        8'h0A: begin
                            w_col_nx  = '0;
                            w_adv_row = 1'b1;
                        end
                        8'h0D: w_col_nx = '0;
                        8'h08: begin
                            if (r_col != '0) begin
                                w_col_nx   = r_col - 7'd1;
                                w_we_nx    = 1'b1;
                                w_waddr_nx = w_cur_addr - ADDR_W'(1);
                                w_wdata_nx = SPACE;
                            end
                        end
                        8'h0C: begin
                            w_state_nx = S_CLR_ALL;
                            w_cnt_nx   = '0;
                            w_col_nx   = '0;
                            w_row_nx   = '0;
                        end
                        default: begin
                            w_we_nx    = 1'b1;
                            w_waddr_nx = w_cur_addr;
                            w_wdata_nx = {{(DATA_W-8){1'b0}}, bus.ch_data};
                            if (r_col == LAST_COL) begin
                                w_col_nx  = '0;
                                w_adv_row = 1'b1;
                            end else begin
                                w_col_nx = r_col + 7'd1;
                            end
                        end
                    endcase
                    if (w_adv_row) begin
                        if (r_row == LAST_ROW) begin
`ifdef VGA_WRITER_SCROLL_EN
                            w_state_nx = S_COPY;
                            w_cnt_nx   = '0;
                            w_raddr_nx = A_COLS;
`else
                            w_row_nx = '0;
`endif
                        end else begin
                            w_row_nx = r_row + 5'd1;
                        end
                    end
                end
            end
`ifdef VGA_WRITER_SCROLL_EN
            S_COPY: begin
                // Read data for index cnt-1 arrives now; write it one row up.
                if (r_cnt != '0) begin
                    w_we_nx    = 1'b1;
                    w_waddr_nx = r_cnt - ADDR_W'(1);
                    w_wdata_nx = bus.vram_rdata;
                end
                if (r_cnt == A_NCOPY) begin
                    w_state_nx = S_CLR_ROW;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + ADDR_W'(1);
                    if (r_cnt < A_NCOPY - ADDR_W'(1))
                        w_raddr_nx = r_cnt + A_COLS + ADDR_W'(1);
                end
            end
            S_CLR_ROW: begin
                w_we_nx    = 1'b1;
                w_waddr_nx = A_NCOPY + r_cnt;
                w_wdata_nx = SPACE;
                if (r_cnt == A_COLS_M1) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + ADDR_W'(1);
                end
            end
`endif
            S_CLR_ALL: begin
                w_we_nx    = 1'b1;
                w_waddr_nx = r_cnt;
                w_wdata_nx = SPACE;
                if (r_cnt == A_LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + ADDR_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ch_ready = (r_state == S_IDLE);
        bus.busy     = (r_state != S_IDLE);
    end

    assign bus.vram_we    = r_we;
    assign bus.vram_waddr = r_waddr;
    assign bus.vram_wdata = r_wdata;
    assign bus.vram_raddr = r_raddr;
    assign bus.cursor_col = r_col;
    assign bus.cursor_row = r_row;
endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: vector table, random stream against a cursor model,
// plus scroll, form-feed and reset-abort sequences against a VRAM model.
module tb_vga_text_writer;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic        pre_we   = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [11:0] pre_data = '0;
    logic [11:0] mem [0:4095];

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int addr; int data; } exp_t;
    typedef struct { logic [7:0] c; bit we; int addr; int data; int col; int row; } vec_t;
    wr_t wq[$];

    vga_text_writer_if u_if ();
    vga_text_writer u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (u_if.vram_we) mem[u_if.vram_waddr[11:0]] <= u_if.vram_wdata;
        u_if.vram_rdata <= mem[u_if.vram_raddr[11:0]];
    end

    always @(posedge clk) begin
        #1;
        if (u_if.vram_we) wq.push_back('{int'(u_if.vram_waddr), int'(u_if.vram_wdata), cyc});
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_we"},    int'(u_if.vram_we), 0);
        chk({t, "_waddr"}, int'(u_if.vram_waddr), 0);
        chk({t, "_wdata"}, int'(u_if.vram_wdata), 0);
        chk({t, "_raddr"}, int'(u_if.vram_raddr), 0);
        chk({t, "_ready"}, int'(u_if.ch_ready), 1);
        chk({t, "_busy"},  int'(u_if.busy), 0);
        chk({t, "_col"},   int'(u_if.cursor_col), 0);
        chk({t, "_row"},   int'(u_if.cursor_row), 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put(input logic [7:0] c);
        int n = 0;
        while (!u_if.ch_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!u_if.ch_ready) begin
            total++;
            bad++;
            $display("FAIL put_timeout ready=0 required=1");
        end
        u_if.ch_valid = 1'b1;
        u_if.ch_data  = c;
        @(posedge clk);
        @(negedge clk);
        u_if.ch_valid = 1'b0;
    endtask

    task automatic do_reset(input string t);
        rst_n = 1'b0;
        #1;
        chk_reset(t);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic preload(input bit by_row, input logic [11:0] v);
        for (int a = 0; a < 2400; a++) begin
            pre_we   = 1'b1;
            pre_addr = 12'(a);
            pre_data = by_row ? 12'(a / 80 + 1) : v;
            @(negedge clk);
        end
        pre_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vt[11];
        exp_t eq[$];
        int   n;
        int   nbad;
        int   mcol;
        int   mrow;
        logic [7:0] c;

        u_if.ch_valid = 1'b0;
        u_if.ch_data  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        vt[0]  = '{8'h41, 1'b1, 0,   'h041, 1, 0};
        vt[1]  = '{8'h42, 1'b1, 1,   'h042, 2, 0};
        vt[2]  = '{8'h08, 1'b1, 1,   'h020, 1, 0};
        vt[3]  = '{8'h0D, 1'b0, 0,   0,     0, 0};
        vt[4]  = '{8'h08, 1'b0, 0,   0,     0, 0};
        vt[5]  = '{8'h0A, 1'b0, 0,   0,     0, 1};
        vt[6]  = '{8'h7A, 1'b1, 80,  'h07A, 1, 1};
        vt[7]  = '{8'h0A, 1'b0, 0,   0,     0, 2};
        vt[8]  = '{8'h0D, 1'b0, 0,   0,     0, 2};
        vt[9]  = '{8'hFF, 1'b1, 160, 'h0FF, 1, 2};
        vt[10] = '{8'h00, 1'b1, 161, 'h000, 2, 2};
        for (int i = 0; i < 11; i++) begin
            put(vt[i].c);
            chk($sformatf("v%0d_ready", i), int'(u_if.ch_ready), 1);
            chk($sformatf("v%0d_we", i), int'(u_if.vram_we), int'(vt[i].we));
            if (vt[i].we) begin
                chk($sformatf("v%0d_waddr", i), int'(u_if.vram_waddr), vt[i].addr);
                chk($sformatf("v%0d_wdata", i), int'(u_if.vram_wdata), vt[i].data);
            end
            chk($sformatf("v%0d_col", i), int'(u_if.cursor_col), vt[i].col);
            chk($sformatf("v%0d_row", i), int'(u_if.cursor_row), vt[i].row);
        end

        // 80 back-to-back printables fill row 0 and wrap the cursor.
        do_reset("rst1");
        wq.delete();
        for (int i = 0; i < 80; i++) put(8'h78);
        @(negedge clk);
        chk("x80_count", wq.size(), 80);
        nbad = 0;
        for (int i = 0; i < wq.size() && i < 80; i++)
            if (wq[i].addr != i || wq[i].data != 'h078 || wq[i].cyc != wq[0].cyc + i) nbad++;
        chk("x80_cells", nbad, 0);
        chk("x80_col", int'(u_if.cursor_col), 0);
        chk("x80_row", int'(u_if.cursor_row), 1);

        put(8'h0A);
        put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h71);
        put(8'h08);
        chk("bs_we", int'(u_if.vram_we), 1);
        chk("bs_waddr", int'(u_if.vram_waddr), 244);
        chk("bs_wdata", int'(u_if.vram_wdata), 'h020);
        chk("bs_col", int'(u_if.cursor_col), 4);
        chk("bs_row", int'(u_if.cursor_row), 3);
        put(8'h0D);
        put(8'h08);
        chk("bs0_we", int'(u_if.vram_we), 0);
        chk("bs0_col", int'(u_if.cursor_col), 0);
        chk("bs0_row", int'(u_if.cursor_row), 3);

        // Random stream against a plain cursor/write model.
        do_reset("rst2");
        wq.delete();
        mcol = 0;
        mrow = 0;
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 9);
            if (mrow >= 25)  c = 8'h0D;
            else if (n == 0) c = 8'h0A;
            else if (n == 1) c = 8'h0D;
            else if (n == 2) c = 8'h08;
            else             c = 8'($urandom_range(32, 126));
            if (c == 8'h0A) begin
                mcol = 0;
                mrow++;
            end else if (c == 8'h0D) begin
                mcol = 0;
            end else if (c == 8'h08) begin
                if (mcol > 0) begin
                    mcol--;
                    eq.push_back('{mrow * 80 + mcol, 'h020});
                end
            end else begin
                eq.push_back('{mrow * 80 + mcol, int'(c)});
                mcol++;
                if (mcol == 80) begin
                    mcol = 0;
                    mrow++;
                end
            end
            put(c);
        end
        @(negedge clk);
        chk("rnd_count", wq.size(), eq.size());
        nbad = 0;
        for (int i = 0; i < wq.size() && i < eq.size(); i++)
            if (wq[i].addr != eq[i].addr || wq[i].data != eq[i].data) nbad++;
        chk("rnd_writes", nbad, 0);
        chk("rnd_col", int'(u_if.cursor_col), mcol);
        chk("rnd_row", int'(u_if.cursor_row), mrow);

        // Line feed on the last row.
        do_reset("rst3");
        preload(1'b1, '0);
        for (int i = 0; i < 29; i++) put(8'h0A);
        chk("lf29_row", int'(u_if.cursor_row), 29);
        put(8'h0A);
`ifdef VGA_WRITER_SCROLL_EN
        n = 0;
        while (!u_if.ch_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("scroll_ready_low", n, 2401);
        @(negedge clk);
        nbad = 0;
        for (int a = 0; a < 2400; a++)
            if (int'(mem[a]) != ((a < 2320) ? (a / 80 + 2) : 'h020)) nbad++;
        chk("scroll_cells", nbad, 0);
        chk("scroll_col", int'(u_if.cursor_col), 0);
        chk("scroll_row", int'(u_if.cursor_row), 29);
`else
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (!u_if.ch_ready) n++;
            @(negedge clk);
        end
        chk("wrap_ready_drop", n, 0);
        nbad = 0;
        for (int a = 0; a < 2400; a++)
            if (int'(mem[a]) != a / 80 + 1) nbad++;
        chk("wrap_cells", nbad, 0);
        chk("wrap_col", int'(u_if.cursor_col), 0);
        chk("wrap_row", int'(u_if.cursor_row), 0);
`endif

        // Form feed clears the whole screen.
        do_reset("rst4");
        preload(1'b0, 12'h111);
        put(8'h61);
        put(8'h62);
        wq.delete();
        put(8'h0C);
        chk("ff_col", int'(u_if.cursor_col), 0);
        chk("ff_row", int'(u_if.cursor_row), 0);
        n = 0;
        while (!u_if.ch_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("ff_ready_low", n, 2400);
        @(negedge clk);
        chk("ff_count", wq.size(), 2400);
        nbad = 0;
        for (int i = 0; i < wq.size() && i < 2400; i++)
            if (wq[i].addr != i || wq[i].data != 'h020 || wq[i].cyc != wq[0].cyc + i) nbad++;
        chk("ff_writes", nbad, 0);
        chk("ff_we_off", int'(u_if.vram_we), 0);

        // Reset partway through a clear aborts it.
        preload(1'b0, 12'h111);
        wq.delete();
        put(8'h0C);
        n = 0;
        while (wq.size() < 1000 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("abort_reached", int'(wq.size() >= 1000), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        nbad = 0;
        for (int a = 0; a < 2400; a++) begin
            if (a < 999 && mem[a] != 12'h020) nbad++;
            if (a >= 1000 && mem[a] != 12'h111) nbad++;
        end
        chk("abort_cells", nbad, 0);
        chk("abort_ready", int'(u_if.ch_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
